if_id_pipe_reg: RTL

IF_ID_PIPE_REG -- requirements
Module: if_id_pipe_reg

---
 rtl/if_id_pipe_reg.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with a one-entry skid buffer.
// Ready towards fetch is decoded from registered state only.
module if_id_pipe_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INSN = 32'h00000013,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_insn,
    input  logic             in_pred_taken,
    input  logic             in_fault,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_insn,
    output logic             out_pred_taken,
    output logic             out_fault,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
        logic            pred_taken;
        logic            fault;
    } entry_t;

    localparam entry_t EMPTY_ENTRY = '{pc: '0, insn: NOP_INSN, pred_taken: 1'b0, fault: 1'b0};

    function automatic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    // A faulted fetch carries no usable instruction; decode sees a NOP.
    function automatic entry_t capture(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] insn,
                                       input logic pred, input logic fault);
        capture.pc         = pc;
        capture.insn       = fault ? NOP_INSN : insn;
        capture.pred_taken = pred;
        capture.fault      = fault;
    endfunction

    state_t state, state_nxt;
    entry_t main_p1, skid_p1, in_entry;
    logic   main_vld_p1;
    logic   in_fire, out_fire;
    logic   ld_main_in, ld_main_skid, ld_skid_in, clr_all;

    assign in_ready  = (state != S_FULL);
    assign occupancy = state;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_vld_p1 & out_ready;
    assign in_entry  = capture(in_pc, in_insn, in_pred_taken, in_fault);

    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        clr_all      = 1'b0;
        if (flush) begin
            state_nxt = S_EMPTY;
            clr_all   = 1'b1;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_nxt  = S_ONE;
                        ld_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        ld_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_nxt  = S_FULL;
                        ld_skid_in = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = S_EMPTY;
                        clr_all   = 1'b1;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        state_nxt    = S_ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_EMPTY;
                    clr_all   = 1'b1;
                end
            endcase
        end
    end

    // stage p1: main/skid registers feeding decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_EMPTY;
            main_vld_p1 <= 1'b0;
            main_p1     <= EMPTY_ENTRY;
            skid_p1     <= EMPTY_ENTRY;
        end else begin
            state       <= state_nxt;
            main_vld_p1 <= (state_nxt != S_EMPTY);
            if (clr_all) begin
                main_p1 <= EMPTY_ENTRY;
                skid_p1 <= EMPTY_ENTRY;
            end else if (ld_main_in) begin
                main_p1 <= in_entry;
            end else if (ld_main_skid) begin
                main_p1 <= skid_p1;
                skid_p1 <= EMPTY_ENTRY;
            end else if (ld_skid_in) begin
                skid_p1 <= in_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_vld_p1 && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign out_valid      = main_vld_p1;
    assign out_pc         = main_p1.pc;
    assign out_insn       = main_p1.insn;
    assign out_pred_taken = main_p1.pred_taken;
    assign out_fault      = main_p1.fault;

endmodule
